// File: rtl/de10_button_pio_in.sv
// Avalon-MM input PIO for push-buttons: two-flop synchroniser, per-bit debounce,
// edge-capture register with write-1-to-clear and a masked level interrupt.
module de10_button_pio_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter bit          INIT_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned     CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] InitVec = {WIDTH{INIT_LEVEL}};

  typedef enum logic {StStable, StPending} db_state_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_hit, w1c;
  logic             wr_en;
  db_state_e        db_q  [WIDTH];
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic             unused_wd;

  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= InitVec;
      sync2_q <= InitVec;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: a new synced level must persist for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q      <= InitVec;
      level_prev_q <= InitVec;
      for (int i = 0; i < int'(WIDTH); i++) begin
        db_q[i]  <= StStable;
        cnt_q[i] <= '0;
      end
    end else begin
      level_prev_q <= level_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        unique case (db_q[i])
          StStable: begin
            if (sync2_q[i] != level_q[i]) begin
              cnt_q[i] <= CntW'(1);
              db_q[i]  <= StPending;
            end else begin
              cnt_q[i] <= '0;
            end
          end
          StPending: begin
            if (sync2_q[i] == level_q[i]) begin
              cnt_q[i] <= '0;
              db_q[i]  <= StStable;
            end else if (cnt_q[i] == CntMax) begin
              level_q[i] <= sync2_q[i];
              cnt_q[i]   <= '0;
              db_q[i]    <= StStable;
            end else begin
              cnt_q[i] <= cnt_q[i] + CntW'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    wr_en = chipselect & ~write_n;
    if (EDGE_TYPE == 0) begin
      edge_hit = level_q & ~level_prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~level_q & level_prev_q;
    end else begin
      edge_hit = level_q ^ level_prev_q;
    end
    w1c       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // A new edge overrides a same-cycle clear so no press is lost.
    edgecap_d = (edgecap_q & ~w1c) | edge_hit;
    irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
  end

  assign irq = |(edgecap_q & irqmask_q);

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata[WIDTH-1:0] = level_q;
        2'd2:    readdata[WIDTH-1:0] = irqmask_q;
        2'd3:    readdata[WIDTH-1:0] = edgecap_q;
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_de10_button_pio_in.sv
// Bench for de10_button_pio_in: falling-edge and any-edge instances share one bus,
// checked by directed sequences and a randomized run against a behavioural model.
module tb_de10_button_pio_in;

  localparam int W  = 4;
  localparam int DC = 4;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [W-1:0] in_port   = 4'hF;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  de10_button_pio_in #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1), .INIT_LEVEL(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a)
  );

  de10_button_pio_in #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2), .INIT_LEVEL(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_b), .irq(irq_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pin history, accepted levels, run of consecutive differing samples.
  logic [W-1:0] m_h1, m_h2, m_st, m_prev, m_mask;
  logic [W-1:0] m_cap [2];
  int           m_run [W];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_h1 = 4'hF; m_h2 = 4'hF; m_st = 4'hF; m_prev = 4'hF; m_mask = '0;
    m_cap[0] = '0; m_cap[1] = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  function automatic logic [31:0] m_rd(input int which);
    logic [31:0] r;
    r = '0;
    if (chipselect) begin
      case (address)
        2'd0: r[W-1:0] = m_st;
        2'd2: r[W-1:0] = m_mask;
        2'd3: r[W-1:0] = m_cap[which];
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // One clock: model next state from pre-edge inputs, commit after the edge.
  task automatic cyc();
    logic [W-1:0] n_st, n_mask, clr, n_cap0, n_cap1, pin;
    int           n_run [W];
    logic         rst, wen;
    rst  = !reset_n;
    pin  = in_port;
    n_st = m_st;
    for (int i = 0; i < W; i++) begin
      if (m_h2[i] != m_st[i]) begin
        n_run[i] = m_run[i] + 1;
        if (n_run[i] == DC) begin
          n_st[i]  = m_h2[i];
          n_run[i] = 0;
        end
      end else begin
        n_run[i] = 0;
      end
    end
    wen    = chipselect && !write_n;
    clr    = (wen && address == 2'd3) ? writedata[W-1:0] : '0;
    n_cap0 = (m_cap[0] & ~clr) | (m_prev & ~m_st);
    n_cap1 = (m_cap[1] & ~clr) | (m_prev ^ m_st);
    n_mask = (wen && address == 2'd2) ? writedata[W-1:0] : m_mask;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_prev = m_st; m_st = n_st; m_run = n_run;
      m_cap[0] = n_cap0; m_cap[1] = n_cap1; m_mask = n_mask;
      m_h2 = m_h1; m_h1 = pin;
    end
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cyc();
    write_n = 1'b1; chipselect = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a,
                        input logic [31:0] exp_a, input logic [31:0] exp_b);
    address = a; chipselect = 1'b1;
    #1;
    check({name, "_a"}, rd_a, exp_a);
    check({name, "_b"}, rd_b, exp_b);
    chipselect = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{addr: 2'd0, cs: 1'b1, exp: 32'hF};
    vt[1] = '{addr: 2'd1, cs: 1'b1, exp: 32'h0};
    vt[2] = '{addr: 2'd2, cs: 1'b1, exp: 32'h0};
    vt[3] = '{addr: 2'd3, cs: 1'b1, exp: 32'h0};
    vt[4] = '{addr: 2'd0, cs: 1'b0, exp: 32'h0};

    model_reset();
    cycn(3);
    reset_n = 1'b1;
    cycn(2);

    // Reset state via the vector table
    for (int i = 0; i < 5; i++) begin
      address = vt[i].addr; chipselect = vt[i].cs;
      #1;
      check($sformatf("reset_vec%0d_a", i), rd_a, vt[i].exp);
      check($sformatf("reset_vec%0d_b", i), rd_b, vt[i].exp);
    end
    chipselect = 1'b0;
    check("reset_irq_a", {31'd0, irq_a}, 32'd0);

    // Press bit 0: DATA changes exactly 6 cycles after the pin
    in_port = 4'hE;
    cycn(5);
    rd_chk("press_lat5", 2'd0, 32'hF, 32'hF);
    cyc();
    rd_chk("press_lat6", 2'd0, 32'hE, 32'hE);
    rd_chk("press_cap_early", 2'd3, 32'h0, 32'h0);
    cyc();
    rd_chk("press_cap", 2'd3, 32'h1, 32'h1);
    check("press_irq_a", {31'd0, irq_a}, 32'd0);

    // Glitch on bit 1 lasting 3 synced cycles is rejected
    in_port = 4'hC;
    cycn(3);
    in_port = 4'hE;
    cycn(8);
    rd_chk("glitch_data", 2'd0, 32'hE, 32'hE);
    rd_chk("glitch_cap", 2'd3, 32'h1, 32'h1);

    // Mask then W1C
    wr(2'd2, 32'h1);
    check("mask_irq_a", {31'd0, irq_a}, 32'd1);
    check("mask_irq_b", {31'd0, irq_b}, 32'd1);
    wr(2'd3, 32'h1);
    rd_chk("w1c_cap", 2'd3, 32'h0, 32'h0);
    check("w1c_irq_a", {31'd0, irq_a}, 32'd0);

    // Release: falling-only ignores it, any-edge captures it
    in_port = 4'hF;
    cycn(8);
    rd_chk("release_data", 2'd0, 32'hF, 32'hF);
    rd_chk("release_cap", 2'd3, 32'h0, 32'h1);
    check("release_irq_b", {31'd0, irq_b}, 32'd1);
    wr(2'd3, 32'hF);
    rd_chk("release_clr", 2'd3, 32'h0, 32'h0);

    // Edge on bit 2 in the same cycle as its W1C: set wins
    in_port = 4'hB;
    cycn(6);
    rd_chk("setwin_pre", 2'd3, 32'h0, 32'h0);
    wr(2'd3, 32'h4);
    rd_chk("setwin_cap", 2'd3, 32'h4, 32'h4);
    wr(2'd2, 32'h4);
    check("setwin_irq_a", {31'd0, irq_a}, 32'd1);

    // Reset while bit 2 is pending release
    in_port = 4'hF;
    cycn(3);
    reset_n = 1'b0;
    #1;
    model_reset();
    rd_chk("rst_data", 2'd0, 32'hF, 32'hF);
    rd_chk("rst_mask", 2'd2, 32'h0, 32'h0);
    rd_chk("rst_cap", 2'd3, 32'h0, 32'h0);
    check("rst_irq_a", {31'd0, irq_a}, 32'd0);
    cycn(2);
    reset_n = 1'b1;
    cycn(10);
    rd_chk("post_rst_data", 2'd0, 32'hF, 32'hF);
    rd_chk("post_rst_cap", 2'd3, 32'h0, 32'h0);

    // Randomized traffic against the model
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(5) == 0) in_port = W'($urandom);
      chipselect = ($urandom_range(3) != 0);
      address    = 2'($urandom);
      writedata  = $urandom;
      write_n    = ($urandom_range(9) >= 2);
      #1;
      check("rand_rd_a", rd_a, m_rd(0));
      check("rand_rd_b", rd_b, m_rd(1));
      check("rand_irq_a", {31'd0, irq_a}, {31'd0, |(m_cap[0] & m_mask)});
      check("rand_irq_b", {31'd0, irq_b}, {31'd0, |(m_cap[1] & m_mask)});
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
